usb_tx_packetizer: RTL and testbench
====================================

USB_TX_PACKETIZER -- requirements
Module: usb_tx_packetizer

Interface
REQ-001: Reset n_rst SHALL be asynchronous and active-low; the clock SHALL be clk.
REQ-002: clk  input  1  system clock; all state updates on rising edge.
REQ-003: n_rst  input  1  asynchronous active-low reset.
REQ-004: tx_start  input  1  single-cycle request to send one packet; sampled only in IDLE.
REQ-005: tx_pid  input  4  PID code of the packet to send; sampled with tx_start.
REQ-006: packet_size  input  7  payload byte count for DATA0/DATA1 (0..64); sampled with tx_start.
REQ-007: tx_data  input  8  head byte of the TX data buffer; valid whenever the buffer is non-empty.
REQ-008: get_tx_data  output  1  one-cycle pop of the TX data buffer.
REQ-009: byte_out  output  8  byte presented to the bit serializer.
REQ-010: byte_valid  output  1  byte_out holds a valid byte.
REQ-011: byte_ready  input  1  serializer accepts byte_out this cycle.
REQ-012: eop_req  output  1  request to the serializer to drive EOP.
REQ-013: eop_ack  input  1  serializer has completed EOP.
REQ-014: tx_busy  output  1  high from the cycle after an accepted tx_start until tx_done.
REQ-015: tx_done  output  1  one-cycle pulse when the packet is fully sent.
REQ-016: tx_error  output  1  one-cycle pulse when tx_start is rejected.

Function
REQ-017: Byte handshake SHALL transfer a byte on a rising edge where byte_valid and byte_ready are both high; byte_out and byte_valid SHALL remain stable until that transfer.
REQ-018: States SHALL be IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE.
REQ-019: IDLE + tx_start + valid PID SHALL go to SYNC next cycle and latch tx_pid and packet_size.
REQ-020: Valid PIDs SHALL be ACK 4'b0010, NAK 4'b1010, STALL 4'b1110, DATA0 4'b0011 and DATA1 4'b1011.
REQ-021: Any other PID, or a DATA PID with packet_size > 64, SHALL pulse tx_error one cycle after tx_start and leave the block in IDLE with no byte_valid.
REQ-022: SYNC SHALL present byte_out = 8'h80 and SHALL go to PID on transfer.
REQ-023: PID SHALL present byte_out = {~pid, pid}.
REQ-024: On transfer from PID, handshake PIDs (ACK/NAK/STALL) SHALL go to EOP.
REQ-025: On transfer from PID, a DATA PID SHALL go to DATA if the latched size is nonzero, otherwise to CRC_LO.
REQ-026: DATA SHALL present byte_out = tx_data and SHALL assert get_tx_data in exactly the transfer cycle of each payload byte.
REQ-027: A 7-bit byte counter SHALL count payload bytes; the transfer of byte number packet_size SHALL go to CRC_LO.
REQ-028: CRC16 SHALL use polynomial x^16+x^15+x^2+1, LSB-first bitwise per byte, initial value 16'hFFFF at SYNC entry, updated on each payload byte transfer.
REQ-029: CRC_LO SHALL send the low byte of the inverted CRC and CRC_HI SHALL send the high byte, in that order.
REQ-030: A zero-length DATA packet SHALL therefore send CRC bytes 8'h00, 8'h00.
REQ-031: EOP SHALL hold eop_req high, with byte_valid low, until eop_ack is seen, then go to DONE.
REQ-032: DONE SHALL pulse tx_done for one cycle and return to IDLE.
REQ-033: tx_start outside IDLE SHALL be ignored, with no tx_error and no effect on the packet in progress.
REQ-034: eop_ack outside EOP SHALL be ignored.
REQ-035: byte_valid SHALL be high only in SYNC, PID, DATA, CRC_LO and CRC_HI.

Reset
REQ-036: On n_rst low, state SHALL go to IDLE immediately.
REQ-037: Reset values SHALL be byte_out=8'h00, byte_valid=0, get_tx_data=0, eop_req=0, tx_busy=0, tx_done=0, tx_error=0, counter=0, CRC=16'hFFFF.
REQ-038: Reset mid-packet SHALL abort the packet with no EOP, no tx_done, and no further get_tx_data.

Verification
REQ-039: ACK: tx_start, tx_pid=4'b0010, byte_ready=1 -> bytes 80, D2; then eop_req until eop_ack; then tx_done pulse; get_tx_data never high.
REQ-040: DATA0, size 0 -> bytes 80, C3, 00, 00; then EOP; then tx_done.
REQ-041: DATA1, size 64, with a buffer model -> bytes 80, 4B, 64 payload bytes, then CRC matching the reference model (LSB byte first); exactly 64 get_tx_data pulses.
REQ-042: Backpressure: byte_ready low for 3 cycles during DATA -> byte_out, byte_valid and the counter held; no get_tx_data until ready.
REQ-043: tx_pid=4'b0001, or DATA0 with size 65 -> tx_error pulse one cycle later; no byte_valid; tx_busy stays 0.
REQ-044: n_rst asserted after 10 payload bytes -> all outputs at reset values; a new ACK then sends normally.

Source files
------------

// File: rtl/usb_tx_packetizer.sv
// usb_tx_packetizer: builds SYNC/PID/payload/CRC16/EOP byte stream for a USB transmitter
module usb_tx_packetizer (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tx_start,
  input  logic [3:0] tx_pid,
  input  logic [6:0] packet_size,
  input  logic [7:0] tx_data,
  output logic       get_tx_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       eop_req,
  input  logic       eop_ack,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);
  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, EOP, DONE} state_t;
  state_t      r_state;
  logic [3:0]  r_pid;
  logic [6:0]  r_size;
  logic [6:0]  r_cnt;
  logic [15:0] r_crc;
  logic        r_err;
  logic        w_pid_hs;
  logic        w_pid_data;
  logic        w_accept;
  logic        w_xfer;
  logic [15:0] w_crc_next;
  // Reflected CRC16 (0x8005 reversed = 0xA001), LSB of each byte first
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) x = x[0] ? ((x >> 1) ^ 16'hA001) : (x >> 1);
    return x;
  endfunction
  assign w_pid_hs   = (tx_pid == 4'b0010) || (tx_pid == 4'b1010) || (tx_pid == 4'b1110);
  assign w_pid_data = (tx_pid[2:0] == 3'b011);
  assign w_accept   = w_pid_hs || (w_pid_data && packet_size <= 7'd64);
  assign w_crc_next = crc_byte(r_crc, tx_data);
  assign w_xfer     = byte_valid && byte_ready;
  // Output decode from the current state; payload byte is the buffer head passed straight through
  always_comb begin
    byte_valid  = (r_state == SYNC) || (r_state == PID) || (r_state == DATA) ||
                  (r_state == CRC_LO) || (r_state == CRC_HI);
    byte_out    = (r_state == SYNC)   ? 8'h80 :
                  (r_state == PID)    ? {~r_pid, r_pid} :
                  (r_state == DATA)   ? tx_data :
                  (r_state == CRC_LO) ? ~r_crc[7:0] :
                  (r_state == CRC_HI) ? ~r_crc[15:8] : 8'h00;
    get_tx_data = (r_state == DATA) && byte_ready;
    eop_req     = (r_state == EOP);
    tx_done     = (r_state == DONE);
    tx_busy     = (r_state != IDLE);
    tx_error    = r_err;
  end
  // Packet sequencer: accepts a request in IDLE and walks the packet fields
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_pid   <= 4'h0;
      r_size  <= 7'd0;
      r_cnt   <= 7'd0;
      r_crc   <= 16'hFFFF;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: if (tx_start) begin
          if (w_accept) begin
            r_state <= SYNC;
            r_pid   <= tx_pid;
            r_size  <= packet_size;
            r_cnt   <= 7'd0;
            r_crc   <= 16'hFFFF;
          end else r_err <= 1'b1;
        end
        SYNC:   if (w_xfer) r_state <= PID;
        PID:    if (w_xfer) r_state <= (r_pid[1:0] == 2'b10) ? EOP : (r_size != 7'd0) ? DATA : CRC_LO;
        DATA: if (w_xfer) begin
          r_cnt <= r_cnt + 7'd1;
          r_crc <= w_crc_next;
          if (r_cnt + 7'd1 == r_size) r_state <= CRC_LO;
        end
        CRC_LO: if (w_xfer) r_state <= CRC_HI;
        CRC_HI: if (w_xfer) r_state <= EOP;
        EOP:    if (eop_ack) r_state <= DONE;
        DONE:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_usb_tx_packetizer.sv
// tb_usb_tx_packetizer: scoreboard bench for the USB TX packetizer
module tb_usb_tx_packetizer;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic [6:0] packet_size = 7'd0;
  logic [7:0] tx_data;
  logic       get_tx_data;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready = 1'b1;
  logic       eop_req;
  logic       eop_ack = 1'b0;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  typedef struct {logic [7:0] b; bit d;} exp_t;
  exp_t exp_q[$];
  logic [7:0] buf_mem [0:255];
  int rd_idx = 0;
  int base = 0;
  int n_tests = 0;
  int n_fail = 0;

  usb_tx_packetizer dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_pid(tx_pid),
    .packet_size(packet_size), .tx_data(tx_data), .get_tx_data(get_tx_data),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .eop_req(eop_req), .eop_ack(eop_ack), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_error(tx_error)
  );

  always #5 clk = ~clk;

  assign tx_data = buf_mem[rd_idx % 256];

  // TX buffer model: pops the head on every get_tx_data edge
  always @(posedge clk) if (get_tx_data) rd_idx <= rd_idx + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every transferred byte is matched against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (n_rst) begin
      if (byte_valid && byte_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, byte_out}, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("byte_out", {24'h0, byte_out}, {24'h0, e.b});
          chk("get_on_xfer", {31'h0, get_tx_data}, {31'h0, e.d});
        end
      end else chk("get_no_xfer", {31'h0, get_tx_data}, 32'h0);
      if (eop_req) chk("valid_in_eop", {31'h0, byte_valid}, 32'h0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit d);
    exp_t e;
    e.b = b;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [3:0] pid, input logic [6:0] sz);
    tx_pid = pid;
    packet_size = sz;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
  endtask

  task automatic wait_gets(input int n);
    int k = 0;
    @(negedge clk);
    while ((rd_idx - base) < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("wait_gets_timeout", {31'h0, k >= 2000}, 32'h0);
  endtask

  task automatic finish_eop;
    int k = 0;
    @(negedge clk);
    while (!eop_req && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("eop_timeout", {31'h0, eop_req}, 32'h1);
    chk("eop_queue_empty", exp_q.size(), 32'h0);
    tick();
    @(negedge clk);
    chk("eop_held", {31'h0, eop_req}, 32'h1);
    chk("no_done_before_ack", {31'h0, tx_done}, 32'h0);
    @(posedge clk);
    #1 eop_ack = 1'b1;
    @(posedge clk);
    #1 eop_ack = 1'b0;
    @(negedge clk);
    chk("tx_done_pulse", {31'h0, tx_done}, 32'h1);
    chk("busy_in_done", {31'h0, tx_busy}, 32'h1);
    chk("eop_dropped", {31'h0, eop_req}, 32'h0);
    tick();
    @(negedge clk);
    chk("tx_done_single", {31'h0, tx_done}, 32'h0);
    chk("busy_after_done", {31'h0, tx_busy}, 32'h0);
  endtask

  task automatic check_reset_vals;
    chk("rst_byte_out", {24'h0, byte_out}, 32'h0);
    chk("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
    chk("rst_get", {31'h0, get_tx_data}, 32'h0);
    chk("rst_eop_req", {31'h0, eop_req}, 32'h0);
    chk("rst_busy", {31'h0, tx_busy}, 32'h0);
    chk("rst_done", {31'h0, tx_done}, 32'h0);
    chk("rst_error", {31'h0, tx_error}, 32'h0);
    chk("rst_cnt", {25'h0, dut.r_cnt}, 32'h0);
    chk("rst_crc", {16'h0, dut.r_crc}, 32'hFFFF);
  endtask

  task automatic bad_start(input logic [3:0] pid, input logic [6:0] sz);
    start(pid, sz);
    @(negedge clk);
    chk("err_pulse", {31'h0, tx_error}, 32'h1);
    chk("err_busy", {31'h0, tx_busy}, 32'h0);
    chk("err_valid", {31'h0, byte_valid}, 32'h0);
    tick();
    @(negedge clk);
    chk("err_single", {31'h0, tx_error}, 32'h0);
    chk("err_busy2", {31'h0, tx_busy}, 32'h0);
    chk("err_valid2", {31'h0, byte_valid}, 32'h0);
  endtask

  // Independent CRC model: non-reflected 0x8005 register fed LSB-first, reflected and inverted at the end
  function automatic logic [15:0] model_crc(input int st, input int n);
    logic [15:0] c;
    logic [15:0] r;
    logic [7:0] d;
    logic fb;
    c = 16'hFFFF;
    for (int j = 0; j < n; j++) begin
      d = buf_mem[(st + j) % 256];
      for (int i = 0; i < 8; i++) begin
        fb = d[i] ^ c[15];
        c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15 - i];
    return ~r;
  endfunction

  initial begin
    logic [7:0] held;
    logic [15:0] crc;
    int gets_before;
    string s;
    for (int i = 0; i < 256; i++) buf_mem[i] = 8'h00;
    tick();
    tick();
    @(negedge clk);
    check_reset_vals();
    #1 n_rst = 1'b1;
    tick();

    // ACK
    base = rd_idx;
    push(8'h80, 0);
    push(8'hD2, 0);
    start(4'b0010, 7'd0);
    @(negedge clk);
    chk("ack_busy", {31'h0, tx_busy}, 32'h1);
    finish_eop();
    chk("ack_no_gets", rd_idx - base, 32'h0);

    // DATA0, zero length
    base = rd_idx;
    push(8'h80, 0);
    push(8'hC3, 0);
    push(8'h00, 0);
    push(8'h00, 0);
    start(4'b0011, 7'd0);
    finish_eop();
    chk("d0z_no_gets", rd_idx - base, 32'h0);

    // DATA0 "123456789" -> CRC16/USB 0xB4C8; stray tx_start while busy
    base = rd_idx;
    s = "123456789";
    for (int i = 0; i < 9; i++) buf_mem[(base + i) % 256] = s[i];
    push(8'h80, 0);
    push(8'hC3, 0);
    for (int i = 0; i < 9; i++) push(s[i], 1);
    push(8'hC8, 0);
    push(8'hB4, 0);
    start(4'b0011, 7'd9);
    tx_pid = 4'b0001;
    tx_start = 1'b1;
    tick();
    tx_start = 1'b0;
    @(negedge clk);
    chk("busy_start_no_err", {31'h0, tx_error}, 32'h0);
    finish_eop();
    chk("d0_9_gets", rd_idx - base, 32'd9);

    // DATA1, 64 bytes with backpressure
    base = rd_idx;
    for (int i = 0; i < 64; i++) buf_mem[(base + i) % 256] = 8'(i * 7 + 3);
    crc = model_crc(base, 64);
    push(8'h80, 0);
    push(8'h4B, 0);
    for (int i = 0; i < 64; i++) push(8'(i * 7 + 3), 1);
    push(crc[7:0], 0);
    push(crc[15:8], 0);
    start(4'b1011, 7'd64);
    wait_gets(5);
    @(posedge clk);
    #1 byte_ready = 1'b0;
    @(negedge clk);
    held = byte_out;
    gets_before = rd_idx;
    chk("bp_byte_is_next", {24'h0, held}, {24'h0, exp_q[0].b});
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      chk("bp_valid", {31'h0, byte_valid}, 32'h1);
      chk("bp_byte_held", {24'h0, byte_out}, {24'h0, held});
      chk("bp_no_pop", rd_idx, gets_before);
    end
    @(posedge clk);
    #1 byte_ready = 1'b1;
    finish_eop();
    chk("d1_64_gets", rd_idx - base, 32'd64);

    // rejected requests
    bad_start(4'b0001, 7'd0);
    bad_start(4'b0011, 7'd65);

    // reset mid-packet
    base = rd_idx;
    for (int i = 0; i < 20; i++) buf_mem[(base + i) % 256] = 8'(8'hA0 + i);
    push(8'h80, 0);
    push(8'hC3, 0);
    for (int i = 0; i < 20; i++) push(8'(8'hA0 + i), 1);
    start(4'b0011, 7'd20);
    wait_gets(10);
    #1 n_rst = 1'b0;
    #1;
    check_reset_vals();
    exp_q.delete();
    gets_before = rd_idx;
    tick();
    tick();
    @(negedge clk);
    chk("rst_no_pop", rd_idx, gets_before);
    chk("rst_no_done", {31'h0, tx_done}, 32'h0);
    chk("rst_no_eop", {31'h0, eop_req}, 32'h0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    tick();

    // ACK after reset
    base = rd_idx;
    push(8'h80, 0);
    push(8'hD2, 0);
    start(4'b0010, 7'd0);
    finish_eop();
    chk("ack2_no_gets", rd_idx - base, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
